// File: rtl/sweep_pkg.sv
// Shared types and constants for the sweep controller and its count register.
package sweep_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/updown_counter.sv
// Loadable up/down count register; load wins over a count step.
module updown_counter
  import sweep_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] cont
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cont <= '0;
    end else if (load) begin
      cont <= load_val;
    end else if (en) begin
      cont <= (dir == DIR_DOWN) ? cont - 1'b1 : cont + 1'b1;
    end
  end

endmodule

// File: rtl/sweep_controller.sv
// Triangle sweep between latched limits, repeated a commanded number of times.
//   state | meaning
//   IDLE  | waiting for a command; cont keeps its last value
//   UP    | counting toward hi
//   DOWN  | counting toward lo
//   DONE  | one-cycle completion pulse
module sweep_controller
  import sweep_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_lo,
  input  logic [WIDTH-1:0] cmd_hi,
  input  logic [3:0]       cmd_sweeps,
  input  logic             hold,
  input  logic             abort,
  output logic [WIDTH-1:0] cont,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lo_q, hi_q;
  logic [3:0]       sweeps_left, sweeps_nxt;
  logic             err_q, err_nxt;
  logic             latch, cnt_load, cnt_en, cnt_dir;
  logic             flat;

  assign flat = (hi_q == lo_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      sweeps_left <= '0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      sweeps_left <= sweeps_nxt;
      err_q       <= err_nxt;
      if (latch) begin
        lo_q <= cmd_lo;
        hi_q <= cmd_hi;
      end
    end
  end

  // A turn at either limit steps away immediately, so each limit is seen for one cycle.
  always_comb begin
    state_nxt  = state;
    sweeps_nxt = sweeps_left;
    err_nxt    = 1'b0;
    latch      = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    cnt_dir    = DIR_UP;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if ((cmd_lo > cmd_hi) || (cmd_sweeps == 4'd0)) begin
            err_nxt = 1'b1;
          end else begin
            latch      = 1'b1;
            cnt_load   = 1'b1;
            sweeps_nxt = cmd_sweeps;
            state_nxt  = UP;
          end
        end
      end
      UP: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (!hold) begin
          if (cont != hi_q) begin
            cnt_en = 1'b1;
          end else begin
            state_nxt = DOWN;
            cnt_en    = !flat;
            cnt_dir   = DIR_DOWN;
          end
        end
      end
      DOWN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (!hold) begin
          if (cont != lo_q) begin
            cnt_en  = 1'b1;
            cnt_dir = DIR_DOWN;
          end else if (sweeps_left > 4'd1) begin
            sweeps_nxt = sweeps_left - 4'd1;
            state_nxt  = UP;
            cnt_en     = !flat;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  updown_counter #(.WIDTH(WIDTH)) u_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cmd_lo),
    .en       (cnt_en),
    .dir      (cnt_dir),
    .cont     (cont)
  );

  assign cmd_ready = (state == IDLE);
  assign dir       = (state == DOWN) ? DIR_DOWN : DIR_UP;
  assign busy      = (state == UP) || (state == DOWN);
  assign done      = (state == DONE);
  assign err       = err_q;

endmodule
